usb_cmd_parser: RTL and testbench
=================================

USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: max idle cycles between words of one frame before the frame is abandoned.
REQ-002 Parameter RST_PULSE_CYC, default 16: cycles rst_sleep holds a reset/sleep code.
REQ-003 usb_clk  in  1  48 MHz clock from the USB chip; the only clock.
REQ-004 sys_rst  in  1  asynchronous, active-low reset.
REQ-005 rx_valid  in  1  one 16-bit word from the FX2 EP2 read path is present on rx_data this cycle.
REQ-006 rx_data  in  16  received word.
REQ-007 rx_ready  out  1  parser accepts a word this cycle; a word is consumed only when rx_valid and rx_ready are both high.
REQ-008 demod_mode  out  4; pga_gain  out  4; demod_chn  out  8: demodulation setup.
REQ-009 ect_freq  out  16; ert_freq  out  16: excitation/sample frequency words.
REQ-010 rst_sleep  out  4: [3] ECT reset, [2] ERT reset, [1] ECT sleep, [0] ERT sleep; 0 = active.
REQ-011 cmd_done  out  1: one-cycle pulse when a valid command is executed.
REQ-012 frm_err  out  1: one-cycle pulse on any discarded frame or word.
REQ-013 err_cnt  out  8: count of frm_err pulses.

Function
REQ-014 A frame is 8 words. W0[7:0] = head 8'h53 and W0[15:8] = command. W1 = demod word. W2 = gain/freq word. W3-W6 are reserved. W7[7:0] = tail 8'hcd.
REQ-015 States: IDLE, BODY, TAIL, EXEC. IDLE waits for W0. BODY takes W1-W6. TAIL takes W7. EXEC lasts one cycle, then returns to IDLE.
REQ-016 In IDLE, a word with [7:0] not equal to 8'h53 is dropped, frm_err pulses, and the state stays IDLE.
REQ-017 In TAIL, W7[7:0] not equal to 8'hcd discards the whole frame, pulses frm_err, and returns to IDLE. No output changes.
REQ-018 rx_ready is high in IDLE, BODY and TAIL, and low in EXEC.
REQ-019 In BODY or TAIL, an inter-word gap counter counts cycles without an accepted word. When it reaches TIMEOUT_CYC, the state goes to IDLE and frm_err pulses. The counter clears on every accepted word.
REQ-020 EXEC decodes the latched command and pulses cmd_done. Outputs update on the EXEC cycle edge.
- 8'ha0: demod_mode <= W1[3:0], pga_gain <= W1[7:4], demod_chn <= W1[15:8].
- 8'h71: ect_freq <= W2. 8'h72: ert_freq <= W2.
- 8'h35 -> rst_sleep 4'b0011; 8'h36 -> 4'b0111; 8'h37 -> 4'b1011.
- 8'h11 -> 4'b1100; 8'h12 -> 4'b1101; 8'h13 -> 4'b1110.
- Any other command: no output change, frm_err pulses instead of cmd_done.
REQ-021 A reset/sleep code holds for exactly RST_PULSE_CYC cycles, then rst_sleep returns to 4'hf.
REQ-022 A new reset/sleep command arriving while a pulse is active replaces the code and restarts the hold count.
REQ-023 A non-reset command arriving during a pulse does not disturb the pulse.
REQ-024 err_cnt increments on each frm_err pulse and saturates at 8'hff.
REQ-025 Reserved words W3-W6 are accepted and ignored, except as stated in REQ-030.

Reset
REQ-026 While sys_rst is low:
- state = IDLE; rx_ready = 0.
- demod_mode = 0, pga_gain = 0, demod_chn = 0.
- ect_freq = 0, ert_freq = 0.
- rst_sleep = 4'hf.
- cmd_done = 0, frm_err = 0, err_cnt = 0.
- All counters cleared.
REQ-027 Reset asserted mid-frame discards the partial frame. The first accepted word after release is treated as W0.
REQ-028 rx_ready goes high on the first usb_clk edge after sys_rst deasserts.

Configuration
REQ-029 Macro USB_CMD_CHKSUM_EN selects checksum checking.
REQ-030 With USB_CMD_CHKSUM_EN defined:
- W6 carries the 16-bit modulo-2^16 sum of W0-W5.
- A mismatch is handled as a tail error (REQ-017).
REQ-031 Without USB_CMD_CHKSUM_EN, W6 is ignored and no checksum logic is built.

Verification
REQ-032 Frame 0xa053, 0x2A15, 0, 0, 0, 0, 0(or checksum), 0x00cd -> demod_mode=5, pga_gain=1, demod_chn=8'h2A, one cmd_done, rx_ready low for 1 cycle.
REQ-033 Frame with cmd 8'h36 -> rst_sleep=4'b0111 for exactly 16 cycles, then 4'hf. A second 8'h12 frame sent mid-pulse -> rst_sleep=4'b1101 for a fresh 16 cycles.
REQ-034 Frame with cmd 8'h71, W2=16'h1388 and tail 8'hce -> ect_freq remains 0, frm_err pulses once, err_cnt=1.
REQ-035 Words 0x0000, 0x1234, then a valid 8'h72 frame with W2=16'h00FA -> two frm_err pulses, ert_freq=16'h00FA.
REQ-036 W0-W3 delivered, then rx_valid low for 255 cycles -> frm_err and return to IDLE. The following full frame is executed normally.
REQ-037 sys_rst pulsed low after W4 of a valid frame -> all outputs at reset values; the next complete frame executes.

Source files
------------

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: frames 8-word commands from the FX2 EP2 read path and
// drives the demodulator setup, frequency words and reset/sleep lines.
// Optional build macro USB_CMD_CHKSUM_EN: W6 must hold the mod-2^16 sum of
// W0-W5; a mismatch discards the frame exactly like a bad tail.
module usb_cmd_parser #(
  parameter int TIMEOUT_CYC   = 255,
  parameter int RST_PULSE_CYC = 16
) (
  input  logic        usb_clk,
  input  logic        sys_rst,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready,
  output logic [3:0]  demod_mode,
  output logic [3:0]  pga_gain,
  output logic [7:0]  demod_chn,
  output logic [15:0] ect_freq,
  output logic [15:0] ert_freq,
  output logic [3:0]  rst_sleep,
  output logic        cmd_done,
  output logic        frm_err,
  output logic [7:0]  err_cnt
);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PUL_W = $clog2(RST_PULSE_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [PUL_W-1:0] PUL_LOAD = PUL_W'(RST_PULSE_CYC);
  localparam logic [7:0] HEAD_B = 8'h53;
  localparam logic [7:0] TAIL_B = 8'hcd;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_TAIL, S_EXEC} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rx_ready;
  logic [2:0]       r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [PUL_W-1:0] r_pul;
  logic [7:0]       r_cmd;
  logic [15:0]      r_w1, r_w2;
  logic [3:0]       r_demod_mode, r_pga_gain, r_rst_sleep;
  logic [7:0]       r_demod_chn, r_err_cnt;
  logic [15:0]      r_ect_freq, r_ert_freq;
  logic             r_cmd_done, r_frm_err;

  logic             w_acc, w_in_frame, w_timeout, w_sum_ok;
  logic             w_err, w_done, w_rst_hit;
  logic [3:0]       w_rst_code;

  assign w_acc      = rx_valid && r_rx_ready;
  assign w_in_frame = (r_state == S_BODY) || (r_state == S_TAIL);
  // The gap counter holds the number of idle cycles already seen, so the
  // frame is dropped on the idle cycle that makes it TIMEOUT_CYC.
  assign w_timeout  = w_in_frame && !w_acc && (r_gap == GAP_LAST);

`ifdef USB_CMD_CHKSUM_EN
  logic [15:0] r_sum;
  logic        r_sum_ok;
  // Running sum of W0-W5, compared against W6 when it arrives
  always_ff @(posedge usb_clk) begin
    if (w_acc) begin
      if (r_state == S_IDLE) begin
        r_sum <= rx_data;
      end else if (r_state == S_BODY) begin
        if (r_idx == 3'd6) r_sum_ok <= (rx_data == r_sum);
        else               r_sum    <= r_sum + rx_data;
      end
    end
  end
  assign w_sum_ok = r_sum_ok;
`else
  assign w_sum_ok = 1'b1;
`endif

  // Frame state register
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode plus the per-cycle error/done/reset-code strobes
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_rst_hit   = 1'b0;
    w_rst_code  = 4'hf;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (rx_data[7:0] == HEAD_B) w_state_nxt = S_BODY;
          else                        w_err       = 1'b1;
        end
      end
      S_BODY: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else if (w_acc && (r_idx == 3'd6)) begin
          w_state_nxt = S_TAIL;
        end
      end
      S_TAIL: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else if (w_acc) begin
          if ((rx_data[7:0] == TAIL_B) && w_sum_ok) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        case (r_cmd)
          8'ha0, 8'h71, 8'h72: w_done = 1'b1;
          8'h35: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b0011; end
          8'h36: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b0111; end
          8'h37: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b1011; end
          8'h11: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b1100; end
          8'h12: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b1101; end
          8'h13: begin w_done = 1'b1; w_rst_hit = 1'b1; w_rst_code = 4'b1110; end
          default: w_err = 1'b1;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake, word index, inter-word gap counter and status pulses
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_rx_ready <= 1'b0;
      r_idx      <= 3'd0;
      r_gap      <= '0;
      r_cmd_done <= 1'b0;
      r_frm_err  <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      r_rx_ready <= (w_state_nxt != S_EXEC);
      r_cmd_done <= w_done;
      r_frm_err  <= w_err;
      if (w_err && (r_err_cnt != 8'hff)) r_err_cnt <= r_err_cnt + 8'h01;
      if (w_acc && (r_state == S_IDLE))      r_idx <= 3'd1;
      else if (w_acc && (r_state == S_BODY)) r_idx <= r_idx + 3'd1;
      if (w_acc || !w_in_frame || w_timeout) r_gap <= '0;
      else                                   r_gap <= r_gap + GAP_W'(1);
    end
  end

  // Frame payload latches; a new head always overwrites stale contents
  always_ff @(posedge usb_clk) begin
    if (w_acc) begin
      if (r_state == S_IDLE) r_cmd <= rx_data[15:8];
      if ((r_state == S_BODY) && (r_idx == 3'd1)) r_w1 <= rx_data;
      if ((r_state == S_BODY) && (r_idx == 3'd2)) r_w2 <= rx_data;
    end
  end

  // Command execution into the setup registers
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_demod_mode <= 4'h0;
      r_pga_gain   <= 4'h0;
      r_demod_chn  <= 8'h00;
      r_ect_freq   <= 16'h0000;
      r_ert_freq   <= 16'h0000;
    end else if (r_state == S_EXEC) begin
      case (r_cmd)
        8'ha0: begin
          r_demod_mode <= r_w1[3:0];
          r_pga_gain   <= r_w1[7:4];
          r_demod_chn  <= r_w1[15:8];
        end
        8'h71:   r_ect_freq <= r_w2;
        8'h72:   r_ert_freq <= r_w2;
        default: ;
      endcase
    end
  end

  // Reset/sleep hold timer; a new code restarts it, other commands leave it
  always_ff @(posedge usb_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_rst_sleep <= 4'hf;
      r_pul       <= '0;
    end else if (w_rst_hit) begin
      r_rst_sleep <= w_rst_code;
      r_pul       <= PUL_LOAD;
    end else if (r_pul != '0) begin
      r_pul <= r_pul - PUL_W'(1);
      if (r_pul == PUL_W'(1)) r_rst_sleep <= 4'hf;
    end
  end

  assign rx_ready   = r_rx_ready;
  assign demod_mode = r_demod_mode;
  assign pga_gain   = r_pga_gain;
  assign demod_chn  = r_demod_chn;
  assign ect_freq   = r_ect_freq;
  assign ert_freq   = r_ert_freq;
  assign rst_sleep  = r_rst_sleep;
  assign cmd_done   = r_cmd_done;
  assign frm_err    = r_frm_err;
  assign err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb_usb_cmd_parser: directed frames against a frame-level model of the
// parser, compared on every falling edge, plus literal spot checks.
module tb_usb_cmd_parser;
  localparam int TIMEOUT = 255;
  localparam int PULSE   = 16;

  logic        usb_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_ready, cmd_done, frm_err;
  logic [3:0]  demod_mode, pga_gain, rst_sleep;
  logic [7:0]  demod_chn, err_cnt;
  logic [15:0] ect_freq, ert_freq;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  usb_cmd_parser #(.TIMEOUT_CYC(TIMEOUT), .RST_PULSE_CYC(PULSE)) dut (
    .usb_clk(usb_clk), .sys_rst(sys_rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .demod_mode(demod_mode), .pga_gain(pga_gain),
    .demod_chn(demod_chn), .ect_freq(ect_freq), .ert_freq(ert_freq),
    .rst_sleep(rst_sleep), .cmd_done(cmd_done), .frm_err(frm_err), .err_cnt(err_cnt)
  );

  always #5 usb_clk = ~usb_clk;

  // Model: expected visible outputs
  logic        exp_ready = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [3:0]  exp_mode = 4'h0, exp_gain = 4'h0, exp_rst = 4'hf;
  logic [7:0]  exp_chn = 8'h00, exp_errcnt = 8'h00;
  logic [15:0] exp_ect = 16'h0000, exp_ert = 16'h0000;
  logic [15:0] m_frm[$];
  bit          m_exec = 1'b0;
  int          m_gap = 0;
  int          m_rem = 0;

  // Observed event counters
  int cnt_done = 0, cnt_nrdy = 0, cnt_0111 = 0, cnt_1101 = 0;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit sum_ok();
`ifdef USB_CMD_CHKSUM_EN
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 0; i < 6; i++) s = s + m_frm[i];
    return s == m_frm[6];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    exp_ready = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_mode = 4'h0; exp_gain = 4'h0; exp_chn = 8'h00;
    exp_ect = 16'h0000; exp_ert = 16'h0000; exp_rst = 4'hf; exp_errcnt = 8'h00;
    m_frm.delete(); m_exec = 1'b0; m_gap = 0; m_rem = 0;
  endtask

  task automatic model_step();
    bit acc, err, load;
    logic [3:0] code;
    acc = rx_valid && exp_ready;
    err = 1'b0; load = 1'b0; code = 4'hf;
    exp_done = 1'b0;
    if (m_exec) begin
      m_exec = 1'b0;
      exp_done = 1'b1;
      case (m_frm[0][15:8])
        8'ha0: begin exp_mode = m_frm[1][3:0]; exp_gain = m_frm[1][7:4]; exp_chn = m_frm[1][15:8]; end
        8'h71: exp_ect = m_frm[2];
        8'h72: exp_ert = m_frm[2];
        8'h35: begin load = 1'b1; code = 4'b0011; end
        8'h36: begin load = 1'b1; code = 4'b0111; end
        8'h37: begin load = 1'b1; code = 4'b1011; end
        8'h11: begin load = 1'b1; code = 4'b1100; end
        8'h12: begin load = 1'b1; code = 4'b1101; end
        8'h13: begin load = 1'b1; code = 4'b1110; end
        default: begin exp_done = 1'b0; err = 1'b1; end
      endcase
      m_frm.delete();
    end else if (acc) begin
      m_gap = 0;
      if (m_frm.size() == 0 && rx_data[7:0] != 8'h53) begin
        err = 1'b1;
      end else begin
        m_frm.push_back(rx_data);
        if (m_frm.size() == 8) begin
          if (m_frm[7][7:0] == 8'hcd && sum_ok()) m_exec = 1'b1;
          else begin err = 1'b1; m_frm.delete(); end
        end
      end
    end else if (m_frm.size() != 0) begin
      m_gap++;
      if (m_gap >= TIMEOUT) begin err = 1'b1; m_frm.delete(); m_gap = 0; end
    end
    if (load) begin
      exp_rst = code; m_rem = PULSE;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) exp_rst = 4'hf;
    end
    exp_err = err;
    if (err && exp_errcnt != 8'hff) exp_errcnt = exp_errcnt + 8'h01;
    exp_ready = !m_exec;
  endtask

  // Model advance on every clock edge and on asynchronous reset
  initial begin
    forever begin
      @(posedge usb_clk or negedge sys_rst);
      if (!sys_rst) model_reset();
      else          model_step();
    end
  end

  // Compare process and event counters
  initial begin
    forever begin
      @(negedge usb_clk);
      if (started) begin
        cmp("rx_ready",   16'(rx_ready),   16'(exp_ready));
        cmp("cmd_done",   16'(cmd_done),   16'(exp_done));
        cmp("frm_err",    16'(frm_err),    16'(exp_err));
        cmp("err_cnt",    16'(err_cnt),    16'(exp_errcnt));
        cmp("demod_mode", 16'(demod_mode), 16'(exp_mode));
        cmp("pga_gain",   16'(pga_gain),   16'(exp_gain));
        cmp("demod_chn",  16'(demod_chn),  16'(exp_chn));
        cmp("ect_freq",   ect_freq,        exp_ect);
        cmp("ert_freq",   ert_freq,        exp_ert);
        cmp("rst_sleep",  16'(rst_sleep),  16'(exp_rst));
        if (cmd_done) cnt_done++;
        if (!rx_ready && sys_rst) cnt_nrdy++;
        if (rst_sleep == 4'b0111) cnt_0111++;
        if (rst_sleep == 4'b1101) cnt_1101++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge usb_clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = w;
    @(negedge usb_clk);
    while (!rx_ready && n < 20) begin n++; @(negedge usb_clk); end
    if (!rx_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_word: rx_ready stuck %b, expected 1 at %0t", rx_ready, $time);
    end
    @(posedge usb_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [7:0] tail);
    logic [15:0] w[8];
    w[0] = {cmd, 8'h53}; w[1] = w1; w[2] = w2;
    w[3] = 16'h0000; w[4] = 16'h0000; w[5] = 16'h0000; w[6] = 16'h0000;
    w[7] = {8'h00, tail};
`ifdef USB_CMD_CHKSUM_EN
    w[6] = w[0] + w[1] + w[2] + w[3] + w[4] + w[5];
`endif
    for (int i = 0; i < 8; i++) send_word(w[i]);
    rx_valid = 1'b0;
  endtask

  initial begin
    #1 sys_rst = 1'b0;
    started = 1'b1;
    tick(3);
    cmp("rst_rx_ready", 16'(rx_ready), 16'h0000);
    cmp("rst_rst_sleep", 16'(rst_sleep), 16'h000f);
    cmp("rst_err_cnt", 16'(err_cnt), 16'h0000);
    sys_rst = 1'b1;
    tick(2);
    cmp("ready_after_rst", 16'(rx_ready), 16'h0001);

    // Demod setup frame
    cnt_done = 0; cnt_nrdy = 0;
    send_frame(8'ha0, 16'h2A15, 16'h0000, 8'hcd);
    tick(4);
    cmp("a0_mode", 16'(demod_mode), 16'h0005);
    cmp("a0_gain", 16'(pga_gain), 16'h0001);
    cmp("a0_chn", 16'(demod_chn), 16'h002A);
    cmp("a0_done_cnt", 16'(cnt_done), 16'h0001);
    cmp("a0_nrdy_cnt", 16'(cnt_nrdy), 16'h0001);

    // Reset/sleep hold length
    cnt_0111 = 0;
    send_frame(8'h36, 16'h0000, 16'h0000, 8'hcd);
    tick(30);
    cmp("pulse36_len", 16'(cnt_0111), 16'h0010);
    cmp("pulse36_end", 16'(rst_sleep), 16'h000f);

    // Replacement code mid-pulse restarts the hold
    cnt_0111 = 0; cnt_1101 = 0;
    send_frame(8'h36, 16'h0000, 16'h0000, 8'hcd);
    send_frame(8'h12, 16'h0000, 16'h0000, 8'hcd);
    tick(30);
    cmp("pulse12_len", 16'(cnt_1101), 16'h0010);
    cmp("pulse36_cut", 16'(cnt_0111 < 16), 16'h0001);

    // Bad tail leaves outputs alone
    send_frame(8'h71, 16'h0000, 16'h1388, 8'hce);
    tick(3);
    cmp("badtail_ect", ect_freq, 16'h0000);
    cmp("badtail_errcnt", 16'(err_cnt), 16'h0001);

    // Two stray words then a valid ERT frequency frame
    send_word(16'h0000);
    send_word(16'h1234);
    send_frame(8'h72, 16'h0000, 16'h00FA, 8'hcd);
    tick(3);
    cmp("ert_freq", ert_freq, 16'h00FA);
    cmp("stray_errcnt", 16'(err_cnt), 16'h0003);

    // Unknown command
    cnt_done = 0;
    send_frame(8'h99, 16'hFFFF, 16'hFFFF, 8'hcd);
    tick(3);
    cmp("unk_errcnt", 16'(err_cnt), 16'h0004);
    cmp("unk_done_cnt", 16'(cnt_done), 16'h0000);

    // Inter-word timeout, then a normal frame
    send_word(16'ha053); send_word(16'h1111); send_word(16'h2222); send_word(16'h3333);
    rx_valid = 1'b0;
    tick(TIMEOUT + 5);
    cmp("timeout_errcnt", 16'(err_cnt), 16'h0005);
    send_frame(8'ha0, 16'h5C3B, 16'h0000, 8'hcd);
    tick(3);
    cmp("post_to_mode", 16'(demod_mode), 16'h000B);
    cmp("post_to_chn", 16'(demod_chn), 16'h005C);

    // Reset mid-frame
    send_word(16'h7153); send_word(16'h0000); send_word(16'hBEEF);
    send_word(16'h0000); send_word(16'h0000);
    rx_valid = 1'b0;
    sys_rst = 1'b0;
    tick(3);
    cmp("mid_rst_mode", 16'(demod_mode), 16'h0000);
    cmp("mid_rst_errcnt", 16'(err_cnt), 16'h0000);
    cmp("mid_rst_ready", 16'(rx_ready), 16'h0000);
    sys_rst = 1'b1;
    tick(2);
    send_frame(8'h71, 16'h0000, 16'h1388, 8'hcd);
    tick(3);
    cmp("post_rst_ect", ect_freq, 16'h1388);

    // Error counter saturation
    rx_valid = 1'b1; rx_data = 16'h0000;
    tick(270);
    rx_valid = 1'b0;
    tick(3);
    cmp("errcnt_sat", 16'(err_cnt), 16'h00ff);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
